// File: rtl/fma_issue_arb.sv
// Round-robin issue of two requesters into a LAT-stage FMA pipe; results leave in order, LAT cycles after issue.
// Backpressure: a blocked head stalls the stages behind it, bubbles ahead still collapse, and no grant is made while stage 0 is held.
module fma_issue_arb #(
  parameter int LAT  = 3,
  parameter int TAGW = 5,
  localparam int CW  = $clog2(LAT + 1)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [1:0]      ReqValid,
  output logic [1:0]      ReqReady,
  input  logic [2:0]      ReqOp0,
  input  logic [2:0]      ReqOp1,
  input  logic [TAGW-1:0] ReqTag0,
  input  logic [TAGW-1:0] ReqTag1,
  input  logic [1:0]      FlushS,
  output logic            IssueSrc,
  output logic [2:0]      FmaOpCtrl,
  output logic [LAT-1:0]  StageEn,
  output logic [1:0]      ResValid,
  input  logic [1:0]      ResReady,
  output logic [TAGW-1:0] ResTag,
  output logic            IllegalOp,
  output logic [CW-1:0]   InFlight,
  output logic            Busy
);

  typedef struct packed {
    logic            v;
    logic            src;
    logic [TAGW-1:0] tag;
  } stage_t;

  stage_t          st_q [LAT];
  stage_t          st_d [LAT];
  stage_t          upin [LAT];
  stage_t          head;
  logic [LAT-1:0]  adv;
  logic            head_fire;
  logic            rr_q;
  logic [CW-1:0]   infl_q;
  logic [CW-1:0]   cnt;
  logic [1:0]      cand;
  logic            grant;
  logic            gsel;
  logic [2:0]      issue_op;
  logic [TAGW-1:0] issue_tag;
  logic            illegal;
  logic            ins;

  // A stage may advance if it, or any stage downstream of it, is empty or the head drains.
  always_comb begin : adv_chain
    logic a;
    head      = st_q[LAT-1];
    head_fire = head.v & ResReady[head.src] & ~FlushS[head.src];
    a         = ~head.v | head_fire;
    adv[LAT-1] = a;
    for (int i = LAT - 2; i >= 0; i--) begin
      a      = ~st_q[i].v | a;
      adv[i] = a;
    end
  end

  always_comb begin
    cand      = ReqValid & ~FlushS;
    grant     = resetn & adv[0] & (|cand);
    gsel      = (&cand) ? rr_q : cand[1];
    issue_op  = gsel ? ReqOp1 : ReqOp0;
    issue_tag = gsel ? ReqTag1 : ReqTag0;
    illegal   = grant & (issue_op == 3'b101);
    ins       = grant & ~illegal;
  end

  // Flushed upstream ops are dropped before they move, so they never occupy a later stage.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < LAT; i++) begin
      if (i == 0) begin
        upin[i].v   = ins;
        upin[i].src = gsel;
        upin[i].tag = issue_tag;
      end else begin
        upin[i]   = st_q[i-1];
        upin[i].v = st_q[i-1].v & ~FlushS[st_q[i-1].src];
      end
      StageEn[i] = adv[i] & upin[i].v;
      if (adv[i]) begin
        st_d[i] = upin[i];
      end else begin
        st_d[i]   = st_q[i];
        st_d[i].v = st_q[i].v & ~FlushS[st_q[i].src];
      end
      cnt = cnt + CW'(st_d[i].v);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LAT; i++) st_q[i] <= '0;
      rr_q   <= 1'b0;
      infl_q <= '0;
    end else begin
      for (int i = 0; i < LAT; i++) st_q[i] <= st_d[i];
      if (grant) rr_q <= ~gsel;
      infl_q <= cnt;
    end
  end

  assign ReqReady  = {grant & gsel, grant & ~gsel};
  assign IssueSrc  = gsel;
  assign FmaOpCtrl = issue_op;
  assign IllegalOp = illegal;
  assign ResValid  = {head.v & head.src & ~FlushS[1], head.v & ~head.src & ~FlushS[0]};
  assign ResTag    = head.tag;
  assign InFlight  = infl_q;
  assign Busy      = |infl_q;

  a_req_onehot: assert property (@(posedge clk) disable iff (!resetn) $onehot0(ReqReady));
  a_res_onehot: assert property (@(posedge clk) disable iff (!resetn) $onehot0(ResValid));
  a_infl_max:   assert property (@(posedge clk) disable iff (!resetn) int'(InFlight) <= LAT);
  a_no_stall_grant: assert property (@(posedge clk) disable iff (!resetn) !((|ReqReady) && !adv[0]));

endmodule

// File: tb/tb_fma_issue_arb.sv
// Directed bench for fma_issue_arb: reset, single op, contention, backpressure, flush, illegal op, async reset.
module tb_fma_issue_arb;
  localparam int LAT  = 3;
  localparam int TAGW = 5;
  localparam int CW   = $clog2(LAT + 1);

  logic            clk;
  logic            resetn;
  logic [1:0]      ReqValid;
  logic [1:0]      ReqReady;
  logic [2:0]      ReqOp0;
  logic [2:0]      ReqOp1;
  logic [TAGW-1:0] ReqTag0;
  logic [TAGW-1:0] ReqTag1;
  logic [1:0]      FlushS;
  logic            IssueSrc;
  logic [2:0]      FmaOpCtrl;
  logic [LAT-1:0]  StageEn;
  logic [1:0]      ResValid;
  logic [1:0]      ResReady;
  logic [TAGW-1:0] ResTag;
  logic            IllegalOp;
  logic [CW-1:0]   InFlight;
  logic            Busy;

  int n_chk  = 0;
  int n_pass = 0;

  fma_issue_arb #(.LAT(LAT), .TAGW(TAGW)) dut (
    .clk(clk), .resetn(resetn),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqOp0(ReqOp0), .ReqOp1(ReqOp1), .ReqTag0(ReqTag0), .ReqTag1(ReqTag1),
    .FlushS(FlushS), .IssueSrc(IssueSrc), .FmaOpCtrl(FmaOpCtrl), .StageEn(StageEn),
    .ResValid(ResValid), .ResReady(ResReady), .ResTag(ResTag),
    .IllegalOp(IllegalOp), .InFlight(InFlight), .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen at the falling edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] v, input logic [TAGW-1:0] t0, input logic [TAGW-1:0] t1);
    ReqValid = v;
    ReqTag0  = t0;
    ReqTag1  = t1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    nxt();
    #2 resetn = 1'b1;
    nxt();
  endtask

  initial begin
    resetn = 1'b0; ReqValid = '0; ReqOp0 = '0; ReqOp1 = '0;
    ReqTag0 = '0; ReqTag1 = '0; FlushS = '0; ResReady = 2'b11;

    // reset state, with requests pending
    #2 ReqValid = 2'b11;
    #1;
    chk("rst_rdy", ReqReady, 0);
    chk("rst_resv", ResValid, 0);
    chk("rst_sten", StageEn, 0);
    chk("rst_infl", InFlight, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_ill", IllegalOp, 0);
    ReqValid = '0;
    nxt();
    #2 resetn = 1'b1;
    nxt();

    // single op, tag 7 from source 0
    drv(2'b01, 7, 0);
    #4 chk("sop_rdy", ReqReady, 2'b01); chk("sop_en", StageEn, 3'b001); chk("sop_src", IssueSrc, 0);
    nxt();
    drv(2'b00, 0, 0);
    #4 chk("sop_inf1", InFlight, 1); chk("sop_en1", StageEn, 3'b010);
    nxt();
    #4 chk("sop_en2", StageEn, 3'b100);
    nxt();
    #4 chk("sop_resv", ResValid, 2'b01); chk("sop_tag", ResTag, 7);
    nxt();
    #4 chk("sop_resv0", ResValid, 0); chk("sop_inf0", InFlight, 0); chk("sop_busy0", Busy, 0);
    nxt();

    // contention: alternating grants, results in issue order
    do_reset();
    for (int k = 0; k < 16; k++) begin
      if (k < 12) drv(2'b11, TAGW'((k + 1) / 2), TAGW'(k / 2));
      else        drv(2'b00, 0, 0);
      #4;
      if (k < 12) chk($sformatf("cont_rdy%0d", k), ReqReady, (k % 2) ? 2 : 1);
      if (k >= 3) begin
        int j;
        j = k - 3;
        if (j < 12) begin
          chk($sformatf("cont_resv%0d", k), ResValid, (j % 2) ? 2 : 1);
          chk($sformatf("cont_tag%0d", k), ResTag, j / 2);
        end else begin
          chk($sformatf("cont_idle%0d", k), ResValid, 0);
        end
      end
      nxt();
    end

    // backpressure on source 0 with bubble collapse
    ResReady = 2'b10;
    drv(2'b01, 10, 0);
    #4 chk("bp_a_rdy", ReqReady, 2'b01);
    nxt();
    drv(2'b00, 0, 0);
    #4 chk("bp_gap_inf", InFlight, 1);
    nxt();
    drv(2'b10, 0, 11);
    #4 chk("bp_b_rdy", ReqReady, 2'b10);
    nxt();
    drv(2'b01, 12, 0);
    #4 chk("bp_c_rdy", ReqReady, 2'b01); chk("bp_hold_v", ResValid, 2'b01); chk("bp_c_en", StageEn, 3'b011);
    nxt();
    drv(2'b01, 13, 0);
    #4 chk("bp_full_rdy", ReqReady, 0); chk("bp_full_en", StageEn, 0); chk("bp_full_inf", InFlight, 3);
    nxt();
    for (int k = 0; k < 2; k++) begin
      #4 chk($sformatf("bp_stall_rdy%0d", k), ReqReady, 0); chk($sformatf("bp_stall_tag%0d", k), ResTag, 10);
      nxt();
    end
    ResReady = 2'b11;
    #4 chk("bp_rel_rdy", ReqReady, 2'b01); chk("bp_rel_resv", ResValid, 2'b01);
    chk("bp_rel_tag", ResTag, 10); chk("bp_rel_en", StageEn, 3'b111);
    nxt();
    drv(2'b00, 0, 0);
    #4 chk("bp_b_resv", ResValid, 2'b10); chk("bp_b_tag", ResTag, 11);
    nxt();
    #4 chk("bp_c_resv", ResValid, 2'b01); chk("bp_c_tag", ResTag, 12);
    nxt();
    #4 chk("bp_d_resv", ResValid, 2'b01); chk("bp_d_tag", ResTag, 13);
    nxt();
    #4 chk("bp_end_resv", ResValid, 0); chk("bp_end_inf", InFlight, 0);
    nxt();

    // flush source 0 with src0/src1/src0 in the pipe
    drv(2'b01, 1, 0);
    #4 chk("fl_t1_rdy", ReqReady, 2'b01);
    nxt();
    drv(2'b10, 0, 2);
    #4 chk("fl_t2_rdy", ReqReady, 2'b10);
    nxt();
    drv(2'b01, 3, 0);
    #4 chk("fl_t3_rdy", ReqReady, 2'b01);
    nxt();
    drv(2'b01, 4, 0);
    FlushS = 2'b01;
    #4 chk("fl_rdy", ReqReady, 0); chk("fl_resv", ResValid, 0); chk("fl_inf3", InFlight, 3);
    nxt();
    FlushS = 2'b00;
    drv(2'b00, 0, 0);
    #4 chk("fl_inf1", InFlight, 1); chk("fl_gap_resv", ResValid, 0);
    nxt();
    #4 chk("fl_t2_resv", ResValid, 2'b10); chk("fl_t2_tag", ResTag, 2);
    nxt();
    #4 chk("fl_end_resv", ResValid, 0); chk("fl_end_inf", InFlight, 0);
    nxt();

    // illegal op from source 1
    drv(2'b10, 0, 9);
    ReqOp1 = 3'b101;
    #4 chk("ill_rdy", ReqReady, 2'b10); chk("ill_pulse", IllegalOp, 1);
    chk("ill_en", StageEn, 0); chk("ill_op", FmaOpCtrl, 3'b101);
    nxt();
    ReqOp1 = 3'b000;
    drv(2'b00, 0, 0);
    #4 chk("ill_inf", InFlight, 0); chk("ill_pulse0", IllegalOp, 0);
    nxt();
    nxt();
    #4 chk("ill_nores", ResValid, 0);
    nxt();

    // async reset with three ops in flight; RR pointer left at 1 beforehand
    drv(2'b11, 20, 21);
    #4 chk("ar_g0", ReqReady, 2'b01);
    nxt();
    #4 chk("ar_g1", ReqReady, 2'b10);
    nxt();
    #4 chk("ar_g2", ReqReady, 2'b01);
    nxt();
    drv(2'b00, 0, 0);
    #1 chk("ar_pre_resv", ResValid, 2'b01); chk("ar_pre_inf", InFlight, 3);
    resetn = 1'b0;
    ReqValid = 2'b11;
    #1;
    chk("ar_resv", ResValid, 0); chk("ar_inf", InFlight, 0); chk("ar_busy", Busy, 0);
    chk("ar_en", StageEn, 0); chk("ar_rdy", ReqReady, 0);
    ReqValid = 2'b00;
    nxt();
    #2 resetn = 1'b1;
    nxt();
    for (int k = 0; k < 4; k++) begin
      #4 chk($sformatf("ar_drop_resv%0d", k), ResValid, 0); chk($sformatf("ar_drop_inf%0d", k), InFlight, 0);
      nxt();
    end
    drv(2'b11, 1, 2);
    #4 chk("ar_first_grant", ReqReady, 2'b01);
    nxt();
    drv(2'b00, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
